// File: rtl/fft_pkg.sv
// Shared types, constants and twiddle tables for the sequential DFT power-spectrum engine.
package fft_pkg;

  typedef enum logic [1:0] {LOAD, MAC, MAG, EMIT} state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // round(127*cos/sin(2*pi*m/N)), i.e. Q1.7 twiddles
  localparam logic signed [7:0] COS4 [4] = '{8'sd127, 8'sd0, -8'sd127, 8'sd0};
  localparam logic signed [7:0] SIN4 [4] = '{8'sd0, 8'sd127, 8'sd0, -8'sd127};

  localparam logic signed [7:0] COS8 [8] = '{8'sd127, 8'sd90, 8'sd0, -8'sd90,
                                            -8'sd127, -8'sd90, 8'sd0, 8'sd90};
  localparam logic signed [7:0] SIN8 [8] = '{8'sd0, 8'sd90, 8'sd127, 8'sd90,
                                            8'sd0, -8'sd90, -8'sd127, -8'sd90};

  localparam logic signed [7:0] COS16 [16] = '{8'sd127, 8'sd117, 8'sd90, 8'sd49,
                                              8'sd0, -8'sd49, -8'sd90, -8'sd117,
                                              -8'sd127, -8'sd117, -8'sd90, -8'sd49,
                                              8'sd0, 8'sd49, 8'sd90, 8'sd117};
  localparam logic signed [7:0] SIN16 [16] = '{8'sd0, 8'sd49, 8'sd90, 8'sd117,
                                              8'sd127, 8'sd117, 8'sd90, 8'sd49,
                                              8'sd0, -8'sd49, -8'sd90, -8'sd117,
                                              -8'sd127, -8'sd117, -8'sd90, -8'sd49};

  function automatic logic signed [7:0] tw_cos(input int n, input logic [3:0] m);
    case (n)
      4:       return COS4[m[1:0]];
      16:      return COS16[m];
      default: return COS8[m[2:0]];
    endcase
  endfunction

  function automatic logic signed [7:0] tw_sin(input int n, input logic [3:0] m);
    case (n)
      4:       return SIN4[m[1:0]];
      16:      return SIN16[m];
      default: return SIN8[m[2:0]];
    endcase
  endfunction

endpackage

// File: rtl/fft_twiddle_rom.sv
// Combinational twiddle lookup: index m -> cos/sin in Q1.(TW_W-1).
// Tables are exact at TW_W=8; other widths are shifted copies of the 8-bit values.
module fft_twiddle_rom
  import fft_pkg::*;
#(
  parameter int N    = 8,
  parameter int TW_W = 8
) (
  input  logic [clog2(N)-1:0] i_m,
  output logic signed [TW_W-1:0] o_cos,
  output logic signed [TW_W-1:0] o_sin
);

  logic [3:0]        w_m4;
  logic signed [7:0] w_c8;
  logic signed [7:0] w_s8;

  assign w_m4 = 4'(i_m);
  assign w_c8 = tw_cos(N, w_m4);
  assign w_s8 = tw_sin(N, w_m4);

  if (TW_W >= 8) begin : g_up
    assign o_cos = TW_W'(w_c8) <<< (TW_W - 8);
    assign o_sin = TW_W'(w_s8) <<< (TW_W - 8);
  end else begin : g_dn
    assign o_cos = TW_W'(w_c8 >>> (8 - TW_W));
    assign o_sin = TW_W'(w_s8 >>> (8 - TW_W));
  end

endmodule

// File: rtl/fft_power_spectrum_seq.sv
// Sequential N-point DFT power spectrum: load N samples, one complex MAC per cycle per bin,
// then scaled/saturated |X[k]|^2 streamed out. Optional peak tracker: FFT_PEAK_DETECT_EN.
module fft_power_spectrum_seq
  import fft_pkg::*;
#(
  parameter int N         = 8,
  parameter int DATA_W    = 8,
  parameter int IN_SIGNED = 0,
  parameter int TW_W      = 8,
  parameter int OUT_W     = 16,
  parameter int MAG_SHIFT = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic [DATA_W-1:0]   s_data,
  input  logic                s_valid,
  output logic                s_ready,
  output logic [OUT_W-1:0]    m_data,
  output logic [clog2(N)-1:0] m_bin,
  output logic                m_valid,
  input  logic                m_ready,
  output logic                m_last,
  output logic                busy
`ifdef FFT_PEAK_DETECT_EN
  ,
  output logic [clog2(N)-1:0] peak_bin,
  output logic [OUT_W-1:0]    peak_mag,
  output logic                peak_valid
`endif
);

  localparam int LOG2N = clog2(N);
  localparam int ACC_W = DATA_W + 1 + TW_W + LOG2N;
  localparam int PW    = 2 * ACC_W + 1;
  localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);

  function automatic logic [PW-1:0] scale_mag(input logic [PW-1:0] p);
    return p >> MAG_SHIFT;
  endfunction

  function automatic logic [OUT_W-1:0] sat_mag(input logic [PW-1:0] p);
    if ((p >> OUT_W) != '0) return '1;
    return p[OUT_W-1:0];
  endfunction

  state_t                  r_state, w_next;
  logic [LOG2N-1:0]        r_n, r_k, w_m;
  logic [DATA_W-1:0]       r_x [N];
  logic signed [DATA_W:0]  w_xe;
  logic signed [TW_W-1:0]  w_cos, w_sin;
  logic signed [ACC_W-1:0] r_acc_re, r_acc_im, w_prod_re, w_prod_im, w_re, w_im;
  logic signed [2*ACC_W-1:0] w_sq_re, w_sq_im;
  logic [PW-1:0]           w_pwr;
  logic                    r_m_valid, r_m_last;
  logic [OUT_W-1:0]        r_m_data;
  logic [LOG2N-1:0]        r_m_bin;
  logic                    w_s_hs, w_m_hs;

  assign w_s_hs = ena & s_valid & (r_state == LOAD);
  assign w_m_hs = ena & r_m_valid & m_ready;

  assign m_data  = r_m_data;
  assign m_bin   = r_m_bin;
  assign m_valid = r_m_valid;
  assign m_last  = r_m_last;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= LOAD;
    else if (ena) r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    s_ready = 1'b0;
    busy    = 1'b1;
    case (r_state)
      LOAD: begin
        s_ready = 1'b1;
        busy    = 1'b0;
        if (s_valid && r_n == LAST) w_next = MAC;
      end
      MAC:  if (r_n == LAST) w_next = MAG;
      MAG:  w_next = EMIT;
      EMIT: if (m_ready) w_next = (r_k == LAST) ? LOAD : MAC;
      default: w_next = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n && w_s_hs) r_x[r_n] <= s_data;
  end

  // MAC term: m = k*n mod N falls out of the LOG2N-bit product truncation
  assign w_m  = r_k * r_n;
  assign w_xe = (IN_SIGNED != 0) ? $signed({r_x[r_n][DATA_W-1], r_x[r_n]})
                                 : $signed({1'b0, r_x[r_n]});

  fft_twiddle_rom #(.N(N), .TW_W(TW_W)) u_rom (
    .i_m   (w_m),
    .o_cos (w_cos),
    .o_sin (w_sin)
  );

  assign w_prod_re = w_xe * w_cos;
  assign w_prod_im = w_xe * w_sin;

  // Magnitude: drop twiddle fraction with floor, then square and sum
  assign w_re    = r_acc_re >>> (TW_W - 1);
  assign w_im    = r_acc_im >>> (TW_W - 1);
  assign w_sq_re = w_re * w_re;
  assign w_sq_im = w_im * w_im;
  assign w_pwr   = {1'b0, w_sq_re} + {1'b0, w_sq_im};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_n       <= '0;
      r_k       <= '0;
      r_acc_re  <= '0;
      r_acc_im  <= '0;
      r_m_valid <= 1'b0;
      r_m_last  <= 1'b0;
      r_m_data  <= '0;
      r_m_bin   <= '0;
    end else if (ena) begin
      case (r_state)
        LOAD: if (w_s_hs) r_n <= r_n + 1'b1;
        MAC: begin
          r_acc_re <= r_acc_re + w_prod_re;
          r_acc_im <= r_acc_im - w_prod_im;
          r_n      <= r_n + 1'b1;
        end
        MAG: begin
          r_m_data  <= sat_mag(scale_mag(w_pwr));
          r_m_bin   <= r_k;
          r_m_last  <= (r_k == LAST);
          r_m_valid <= 1'b1;
          r_acc_re  <= '0;
          r_acc_im  <= '0;
        end
        EMIT: if (w_m_hs) begin
          r_m_valid <= 1'b0;
          r_m_last  <= 1'b0;
          r_k       <= r_k + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef FFT_PEAK_DETECT_EN
  logic [OUT_W-1:0] r_run_mag, r_peak_mag, w_pk_mag;
  logic [LOG2N-1:0] r_run_bin, r_peak_bin, w_pk_bin;
  logic             r_peak_valid, w_pk_take;

  // Strict greater-than keeps the lowest bin on ties; bin 0 restarts the search
  assign w_pk_take = (r_m_bin == '0) || (r_m_data > r_run_mag);
  assign w_pk_mag  = w_pk_take ? r_m_data : r_run_mag;
  assign w_pk_bin  = w_pk_take ? r_m_bin  : r_run_bin;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_run_mag    <= '0;
      r_run_bin    <= '0;
      r_peak_mag   <= '0;
      r_peak_bin   <= '0;
      r_peak_valid <= 1'b0;
    end else if (ena) begin
      r_peak_valid <= 1'b0;
      if (w_m_hs) begin
        r_run_mag <= w_pk_mag;
        r_run_bin <= w_pk_bin;
        if (r_m_last) begin
          r_peak_mag   <= w_pk_mag;
          r_peak_bin   <= w_pk_bin;
          r_peak_valid <= 1'b1;
        end
      end
    end
  end

  assign peak_bin   = r_peak_bin;
  assign peak_mag   = r_peak_mag;
  assign peak_valid = r_peak_valid;
`else
  // Peak tracking compiled out; the core datapath is unchanged.
`endif

endmodule

// File: tb/tb_fft_power_spectrum_seq.sv
// Scoreboard bench for fft_power_spectrum_seq (N=8) with a second OUT_W=12 instance run in lockstep.
module tb_fft_power_spectrum_seq;

  localparam int N = 8;

  typedef struct packed {
    logic [7:0][7:0]  x;
    logic [7:0][31:0] e;
  } vec_t;

  typedef struct {
    int bin;
    int d16;
    int d12;
    bit last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = '0;
  logic        m_ready;
  logic        s_ready, m_valid, m_last, busy;
  logic [15:0] m_data;
  logic [2:0]  m_bin;
  logic        sat_s_ready, sat_m_valid, sat_m_last, sat_busy;
  logic [11:0] sat_m_data;
  logic [2:0]  sat_m_bin;
`ifdef FFT_PEAK_DETECT_EN
  logic [2:0]  peak_bin, sat_peak_bin;
  logic [15:0] peak_mag;
  logic [11:0] sat_peak_mag;
  logic        peak_valid, sat_peak_valid;
`endif

  int   n_vec = 0;
  int   n_err = 0;
  bit   bp_mode = 0;
  exp_t q[$];
  int   exp_pk_bin, exp_pk_mag, pk_cycles;
  bit   stall_prev = 0;
  logic [15:0] st_data;
  logic [2:0]  st_bin;
  logic        st_last;
  vec_t vt [5];

  always #5 clk = ~clk;

  fft_power_spectrum_seq #(.N(N), .DATA_W(8), .IN_SIGNED(0), .TW_W(8), .OUT_W(16), .MAG_SHIFT(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_bin(m_bin), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last), .busy(busy)
`ifdef FFT_PEAK_DETECT_EN
    , .peak_bin(peak_bin), .peak_mag(peak_mag), .peak_valid(peak_valid)
`endif
  );

  fft_power_spectrum_seq #(.N(N), .DATA_W(8), .IN_SIGNED(0), .TW_W(8), .OUT_W(12), .MAG_SHIFT(8)) u_sat (
    .clk(clk), .rst_n(rst_n), .ena(ena), .s_data(s_data), .s_valid(s_valid), .s_ready(sat_s_ready),
    .m_data(sat_m_data), .m_bin(sat_m_bin), .m_valid(sat_m_valid), .m_ready(m_ready), .m_last(sat_m_last),
    .busy(sat_busy)
`ifdef FFT_PEAK_DETECT_EN
    , .peak_bin(sat_peak_bin), .peak_mag(sat_peak_mag), .peak_valid(sat_peak_valid)
`endif
  );

  task automatic chk(input string nm, input longint act, input longint req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  // ena / m_ready driver: random in backpressure mode, otherwise both held high
  initial begin
    ena = 1'b1;
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bp_mode) begin
        m_ready = 1'($urandom_range(0, 1));
        ena     = ($urandom_range(0, 3) != 0);
      end else begin
        m_ready = 1'b1;
        ena     = 1'b1;
      end
    end
  end

  // Output monitor: scoreboard pops on handshakes, stall stability, peak checks
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_prev = 0;
      end else begin
        if (stall_prev) begin
          chk("stall_valid", m_valid, 1);
          chk("stall_data", m_data, st_data);
          chk("stall_bin", m_bin, st_bin);
          chk("stall_last", m_last, st_last);
        end
        if (m_valid && m_ready && ena) begin
          if (q.size() == 0) begin
            chk("unexpected_output", 1, 0);
          end else begin
            e = q.pop_front();
            chk("m_bin", m_bin, e.bin);
            chk("m_data", m_data, e.d16);
            chk("m_last", m_last, e.last);
            chk("sat_m_valid", sat_m_valid, 1);
            chk("sat_m_data", sat_m_data, e.d12);
          end
        end
        stall_prev = m_valid && !(m_ready && ena);
        st_data = m_data;
        st_bin  = m_bin;
        st_last = m_last;
`ifdef FFT_PEAK_DETECT_EN
        if (peak_valid) begin
          pk_cycles++;
          chk("peak_bin", peak_bin, exp_pk_bin);
          chk("peak_mag", peak_mag, exp_pk_mag);
        end
`endif
      end
    end
  end

  task automatic send_samples(input logic [7:0][7:0] x, input int cnt);
    int  guard;
    bit  hs;
    for (int i = 0; i < cnt; i++) begin
      s_valid = 1'b1;
      s_data  = x[i];
      guard = 0;
      hs = 0;
      while (!hs && guard < 200) begin
        @(negedge clk);
        hs = s_ready && ena;
        guard++;
      end
      if (!hs) begin
        chk("input_handshake_timeout", 0, 1);
        s_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
  endtask

  task automatic run_frame(input vec_t v, input bit bp, input bit lat);
    exp_t e;
    int   guard, pb, pm;
    bit   sr_bad;
    bp_mode = bp;
    pk_cycles = 0;
    send_samples(v.x, N);
    pb = 0;
    pm = int'(v.e[0]);
    for (int i = 1; i < N; i++)
      if (int'(v.e[i]) > pm) begin pm = int'(v.e[i]); pb = i; end
    exp_pk_bin = pb;
    exp_pk_mag = pm;
    for (int i = 0; i < N; i++) begin
      e.bin  = i;
      e.d16  = int'(v.e[i]);
      e.d12  = (int'(v.e[i]) > 4095) ? 4095 : int'(v.e[i]);
      e.last = (i == N - 1);
      q.push_back(e);
    end
    chk("busy_after_load", busy, 1);
    if (lat) begin
      guard = 0;
      do begin
        @(negedge clk);
        guard++;
      end while (!m_valid && guard < 100);
      chk("first_valid_latency", guard, N + 2);
    end
    sr_bad = 0;
    guard = 0;
    while (q.size() > 0 && guard < 3000) begin
      @(negedge clk);
      #2;
      if (s_ready) sr_bad = 1;
      guard++;
    end
    chk("frame_outputs_pending", q.size(), 0);
    q.delete();
    chk("s_ready_low_during_frame", sr_bad, 0);
    bp_mode = 0;
    @(negedge clk);
    #2;
    chk("s_ready_after_last", s_ready, 1);
    chk("busy_after_last", busy, 0);
`ifdef FFT_PEAK_DETECT_EN
    @(negedge clk);
    #2;
    chk("peak_pulse_cycles", pk_cycles, 1);
`endif
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    vt[0].x = {8{8'd100}};
    vt[0].e = {224'd0, 32'd2456};
    vt[1].x = {56'd0, 8'd64};
    vt[1].e = {8{32'd15}};
    vt[2].x = {8'd0, 8'd100, 8'd0, 8'd100, 8'd0, 8'd100, 8'd0, 8'd100};
    vt[2].e = {32'd0, 32'd0, 32'd0, 32'd612, 32'd0, 32'd0, 32'd0, 32'd612};
    vt[3].x = {8{8'd255}};
    vt[3].e = {224'd0, 32'd16002};
    vt[4] = vt[1];

    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_ready", s_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_bin", m_bin, 0);
`ifdef FFT_PEAK_DETECT_EN
    chk("rst_peak_valid", peak_valid, 0);
    chk("rst_peak_mag", peak_mag, 0);
`endif
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 5; i++) run_frame(vt[i], (i == 4), (i == 0));

    // Partial frame abandoned by reset
    send_samples(vt[0].x, 5);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_s_ready", s_ready, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_m_valid", m_valid, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_frame(vt[0], 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
